run_sequencer: RTL and testbench

Batch run controller for the lab3 CPU: holds a parametrised table of program entry addresses and issues them back-to-back, for one `go_i`. For each run it:
- pulses the CPU start input with the entry address,
- waits for done,
- reports the dynamic cycle count.

Runs that never finish are stopped by a saturating timeout. Sits between host/bench logic and the CPU's `start_i`/`start_addr`/`done` ports, replacing hand-sequenced start pulses.

---
 rtl/run_seq_pkg.sv | 20 ++
 rtl/run_seq_counter.sv | 40 ++++
 rtl/run_sequencer.sv | 147 ++++++++++++++
 tb/tb_run_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and helpers for the run_sequencer batch controller.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package run_seq_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RECORD = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // All-ones value of a w-bit counter, i.e. the timeout threshold in cycles.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/run_seq_counter.sv
// Saturating run-cycle counter: load-to-1, count-enable, saturation flag.
// Latency: count visible one cycle after load/enable.
// Backpressure: none; saturates at all-ones instead of wrapping.
// Ports: clock_i/reset_i clock and async reset; load1_i forces count to 1;
//        en_i increments; cnt_o current count; sat_o count is all-ones.
module run_seq_counter
  import run_seq_pkg::*;
#(
  parameter int CNT_W = 15
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load1_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load1_i) begin
      cnt_d = CNT_W'(1);
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/run_sequencer.sv
// Batch run controller: launches table entry addresses on the CPU back-to-back and reports per-run cycle counts.
// Latency: go -> cpu_start 1 cycle; done -> run_valid 1 cycle; run_valid -> next cpu_start 1 cycle.
// Backpressure: none; report/batch outputs are single-cycle pulses, stuck runs are cut off by a saturating timeout.
// Ports: clock_i/reset_i; load_* table write port (IDLE only); go_i/run_count_i batch start;
//        cpu_done_i/cpu_start_o/cpu_start_addr_o CPU handshake; busy_o, run_*_o, timeout_o, batch_done_o status.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int NUM_RUNS = 4,
  parameter int CNT_W    = 15,
  parameter int IDX_W    = $clog2(NUM_RUNS + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_en_i,
  input  logic [IDX_W-1:0]  load_idx_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              go_i,
  input  logic [IDX_W-1:0]  run_count_i,
  input  logic              cpu_done_i,
  output logic              cpu_start_o,
  output logic [ADDR_W-1:0] cpu_start_addr_o,
  output logic              busy_o,
  output logic              run_valid_o,
  output logic [IDX_W-1:0]  run_idx_o,
  output logic [CNT_W-1:0]  run_cycles_o,
  output logic              timeout_o,
  output logic              batch_done_o
);

  // Table is rounded up to a power of two so it can be indexed by a plain slice;
  // writes are gated to idx < NUM_RUNS, so any extra entries stay at zero.
  localparam int               TBL_AW   = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1;
  localparam int               TBL_D    = 1 << TBL_AW;
  localparam logic [IDX_W-1:0] RUNS_MAX = IDX_W'(NUM_RUNS);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, n_q, n_d, n_clamp, idx_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d, cnt;
  logic              timeout_q, timeout_d;
  logic              cnt_load, cnt_en, cnt_sat;
  logic [ADDR_W-1:0] table_q [TBL_D];

  assign n_clamp = (run_count_i > RUNS_MAX) ? RUNS_MAX : run_count_i;
  assign idx_inc = idx_q + IDX_W'(1);

  run_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load1_i (cnt_load),
    .en_i    (cnt_en),
    .cnt_o   (cnt),
    .sat_o   (cnt_sat)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    addr_d    = addr_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          timeout_d = 1'b0;
          n_d       = n_clamp;
          idx_d     = '0;
          if (n_clamp != '0) begin
            addr_d  = table_q[0];
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        // Done while the count is still 1 is the previous run's level, not ours.
        // Done is checked first so it beats a simultaneous saturation.
        if (cpu_done_i && (cnt > CNT_W'(1))) begin
          cycles_d = cnt;
          state_d  = ST_RECORD;
        end else if (cnt_sat) begin
          cycles_d  = cnt;
          timeout_d = 1'b1;
          state_d   = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (timeout_q || (idx_inc == n_q)) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_inc;
          addr_d  = table_q[idx_inc[TBL_AW-1:0]];
          state_d = ST_LAUNCH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < TBL_D; i++) table_q[i] <= '0;
    end else if ((state_q == ST_IDLE) && load_en_i && (load_idx_i < RUNS_MAX)) begin
      table_q[load_idx_i[TBL_AW-1:0]] <= load_addr_i;
    end
  end

  assign cpu_start_o      = (state_q == ST_LAUNCH);
  assign cpu_start_addr_o = addr_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign run_valid_o      = (state_q == ST_RECORD);
  assign run_idx_o        = idx_q;
  assign run_cycles_o     = cycles_q;
  assign timeout_o        = timeout_q;
  assign batch_done_o     = (state_q == ST_FINISH);

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  localparam int ADDR_W   = 8;
  localparam int NUM_RUNS = 4;
  localparam int CNT_W    = 15;
  localparam int IDX_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic              rst, load_en, go, cpu_done;
  logic [IDX_W-1:0]  load_idx, run_count;
  logic [ADDR_W-1:0] load_addr;
  logic              cpu_start, busy, run_valid, timeout, batch_done;
  logic [ADDR_W-1:0] cpu_addr;
  logic [IDX_W-1:0]  run_idx;
  logic [CNT_W-1:0]  run_cycles;

  // small-counter instance for the timeout boundary
  logic              go4, done4;
  logic [2:0]        count4;
  logic              start4, busy4, valid4, timeout4, bdone4;
  logic [7:0]        addr4;
  logic [2:0]        idx4;
  logic [3:0]        cycles4;

  run_sequencer #(.ADDR_W(ADDR_W), .NUM_RUNS(NUM_RUNS), .CNT_W(CNT_W)) u_dut (
    .clock_i(clk), .reset_i(rst), .load_en_i(load_en), .load_idx_i(load_idx),
    .load_addr_i(load_addr), .go_i(go), .run_count_i(run_count), .cpu_done_i(cpu_done),
    .cpu_start_o(cpu_start), .cpu_start_addr_o(cpu_addr), .busy_o(busy),
    .run_valid_o(run_valid), .run_idx_o(run_idx), .run_cycles_o(run_cycles),
    .timeout_o(timeout), .batch_done_o(batch_done)
  );

  run_sequencer #(.ADDR_W(8), .NUM_RUNS(4), .CNT_W(4)) u_dut4 (
    .clock_i(clk), .reset_i(rst), .load_en_i(1'b0), .load_idx_i(3'd0),
    .load_addr_i(8'd0), .go_i(go4), .run_count_i(count4), .cpu_done_i(done4),
    .cpu_start_o(start4), .cpu_start_addr_o(addr4), .busy_o(busy4),
    .run_valid_o(valid4), .run_idx_o(idx4), .run_cycles_o(cycles4),
    .timeout_o(timeout4), .batch_done_o(bdone4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference model state
  typedef struct { int idx; int cyc; } rep_t;
  logic [ADDR_W-1:0] tbl_m [NUM_RUNS];
  logic [ADDR_W-1:0] exp_start_q [$];
  rep_t              exp_rep_q [$];
  int                delay_q [$];     // per-launch done delay for the CPU model, 0 = never
  int                bdone_pending = 0;
  bit                stale_req = 1'b0;

  // CPU model: raises done (level) 'delay' cycles after the start cycle.
  int remaining = 0;
  int j = 1000;
  bit armed = 1'b0;
  bit hold = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b0; hold = 1'b0; j = 1000; remaining = 0;
    end else if (cpu_start) begin
      remaining = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
      armed = (remaining != 0);
      hold = stale_req;
      j = 0;
    end else begin
      j++;
      if (j == 2) hold = 1'b0;
    end
    cpu_done = hold || (stale_req && !busy) || (armed && (j >= remaining));
  end

  // CPU model for the small instance
  int c4 = 0;
  int d4 = 0;
  always @(negedge clk) begin
    if (rst) c4 = 0;
    else if (start4) c4 = 0;
    else c4++;
    done4 = (d4 != 0) && (c4 >= d4);
  end

  // scoreboard monitor
  bit prev_valid = 1'b0;
  logic [ADDR_W-1:0] mon_addr;
  rep_t mon_rep;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && exp_start_q.size() != 0) check("b2b_start", cpu_start, 1);
      if (cpu_start) begin
        check("start_expected", exp_start_q.size() != 0, 1);
        if (exp_start_q.size() != 0) begin
          mon_addr = exp_start_q.pop_front();
          check("start_addr", cpu_addr, mon_addr);
        end
      end
      if (run_valid) begin
        check("report_expected", exp_rep_q.size() != 0, 1);
        if (exp_rep_q.size() != 0) begin
          mon_rep = exp_rep_q.pop_front();
          check("run_idx", run_idx, mon_rep.idx);
          check("run_cycles", run_cycles, mon_rep.cyc);
        end
      end
      if (batch_done) begin
        check("batch_done_expected", bdone_pending != 0, 1);
        if (bdone_pending != 0) bdone_pending--;
      end
      prev_valid = run_valid;
    end
  end

  task automatic load(input int idx, input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    load_en = 1'b1; load_idx = IDX_W'(idx); load_addr = addr;
    @(negedge clk);
    load_en = 1'b0;
    if (idx < NUM_RUNS) tbl_m[idx] = addr;
  endtask

  // Issue one batch; expected starts/reports come from the table model and the
  // CPU delays. poke != 0 drives go and a table write at that cycle of the batch.
  task automatic run_batch(input int count, input int d0, input int d1, input int d2,
                           input int d3, input int poke);
    int dl[4];
    int n, total, cyc, c;
    bit to;
    dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    n = (count > NUM_RUNS) ? NUM_RUNS : count;
    total = 1;
    to = 1'b0;
    for (int i = 0; i < n && !to; i++) begin
      exp_start_q.push_back(tbl_m[i]);
      delay_q.push_back(dl[i]);
      if (dl[i] == 0 || dl[i] > CNT_MAX) begin c = CNT_MAX; to = 1'b1; end
      else c = dl[i];
      exp_rep_q.push_back('{idx: i, cyc: c});
      total += c + 2;
    end
    bdone_pending++;
    @(negedge clk);
    go = 1'b1; run_count = IDX_W'(count);
    @(negedge clk);
    go = 1'b0;
    check("go_to_start", cpu_start, n != 0);
    cyc = 1;
    while (!batch_done && cyc < total + 100) begin
      @(negedge clk);
      cyc++;
      if (poke != 0 && cyc == poke) begin
        go = 1'b1; run_count = 3'd2; load_en = 1'b1; load_idx = '0; load_addr = ~tbl_m[0];
      end else if (poke != 0 && cyc == poke + 1) begin
        go = 1'b0; load_en = 1'b0;
      end
    end
    check("batch_latency", cyc, total);
    check("timeout_flag", timeout, to);
    @(negedge clk);
    check("idle_after_batch", busy, 0);
    check("all_runs_seen", exp_start_q.size() + exp_rep_q.size(), 0);
  endtask

  // Small instance: two-run batch, first run finishes after d cycles (0 = never).
  task automatic t4(input int d, input int exp_cyc, input bit exp_to);
    int starts, reps, first_cyc, seen, to_at;
    d4 = d;
    starts = 0; reps = 0; first_cyc = -1; seen = 0; to_at = -1;
    @(negedge clk);
    go4 = 1'b1; count4 = 3'd2;
    @(negedge clk);
    go4 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (start4) starts++;
      if (valid4 && reps == 0) first_cyc = int'(cycles4);
      if (valid4) reps++;
      if (bdone4) begin seen = 1; to_at = int'(timeout4); break; end
      @(negedge clk);
    end
    check("t4_batch_done", seen, 1);
    check("t4_cycles", first_cyc, exp_cyc);
    check("t4_timeout", to_at, exp_to);
    check("t4_starts", starts, exp_to ? 1 : 2);
    check("t4_reports", reps, exp_to ? 1 : 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, seen;
    rst = 1'b1; load_en = 1'b0; load_idx = '0; load_addr = '0; go = 1'b0; run_count = '0;
    go4 = 1'b0; count4 = '0;
    for (int i = 0; i < NUM_RUNS; i++) tbl_m[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_start", cpu_start, 0);
    check("rst_cpu_addr", cpu_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_run_valid", run_valid, 0);
    check("rst_run_idx", run_idx, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_timeout", timeout, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst4_busy", busy4, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // three-run batch
    load(0, 8'd0); load(1, 8'd93); load(2, 8'd138);
    run_batch(3, 10, 20, 30, 0, 0);

    // stale done across the start pulse
    stale_req = 1'b1;
    run_batch(1, 5, 0, 0, 0, 0);
    stale_req = 1'b0;

    // count edge cases
    run_batch(0, 0, 0, 0, 0, 0);
    load(3, 8'd201);
    run_batch(7, 3, 4, 5, 6, 0);

    // out-of-range load ignored, then go/load while busy ignored
    load(5, 8'hFF);
    run_batch(4, 2, 2, 2, 2, 0);
    run_batch(2, 12, 8, 0, 0, 5);
    run_batch(1, 4, 0, 0, 0, 0);

    // randomized batches
    repeat (8) begin
      load($urandom_range(0, 5), ADDR_W'($urandom));
      load($urandom_range(0, 5), ADDR_W'($urandom));
      run_batch($urandom_range(0, 7), $urandom_range(2, 40), $urandom_range(2, 40),
                $urandom_range(2, 40), $urandom_range(2, 40), 0);
    end

    // timeout boundary on the 4-bit counter
    t4(0, 15, 1'b1);
    @(negedge clk);
    go4 = 1'b1; count4 = 3'd0;
    @(negedge clk);
    go4 = 1'b0;
    check("t4_go_clears_timeout", timeout4, 0);
    check("t4_zero_count_done", bdone4, 1);
    t4(15, 15, 1'b0);
    t4(14, 14, 1'b0);

    // reset in the WAIT state of run 1
    load(0, 8'h11); load(1, 8'h22);
    exp_start_q.push_back(tbl_m[0]);
    exp_rep_q.push_back('{idx: 0, cyc: 6});
    exp_start_q.push_back(tbl_m[1]);
    delay_q.push_back(6);
    delay_q.push_back(20);
    @(negedge clk);
    go = 1'b1; run_count = 3'd3;
    @(negedge clk);
    go = 1'b0;
    c = 0;
    while (!run_valid && c < 50) begin @(negedge clk); c++; end
    check("rst_reached_run0_report", run_valid, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_cpu_start", cpu_start, 0);
    check("arst_cpu_addr", cpu_addr, 0);
    check("arst_busy", busy, 0);
    check("arst_run_valid", run_valid, 0);
    check("arst_run_idx", run_idx, 0);
    check("arst_run_cycles", run_cycles, 0);
    check("arst_timeout", timeout, 0);
    check("arst_batch_done", batch_done, 0);
    exp_start_q.delete();
    exp_rep_q.delete();
    delay_q.delete();
    for (int i = 0; i < NUM_RUNS; i++) tbl_m[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (run_valid || batch_done || busy) seen++;
    end
    check("no_activity_after_reset", seen, 0);
    run_batch(2, 3, 4, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
